// File: rtl/or1200_freeze_pkg.sv
// Shared definitions for the or1200 pipeline freeze sequencer.
//   state_t    : sequencer FSM states (IDLE, MC, WAIT)
//   WAIT_*     : wait_on unit codes, also used to select the matching wait_done strobe
package or1200_freeze_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MC   = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [1:0] WAIT_NONE   = 2'd0;
  localparam logic [1:0] WAIT_MULMAC = 2'd1;
  localparam logic [1:0] WAIT_FPU    = 2'd2;
  localparam logic [1:0] WAIT_MTSPR  = 2'd3;

endpackage

// File: rtl/or1200_freeze_cnt.sv
// Loadable down-counter with zero flag; holds the remaining multicycle EX count.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous clear (pipeline flush)
//   load      : load load_val (takes priority over dec)
//   dec       : decrement by one, stops at zero
//   cnt, zero : current count and cnt==0 flag
module or1200_freeze_cnt
  import or1200_freeze_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/or1200_freeze_seq.sv
// Pipeline freeze/flush sequencer for the or1200_ctrl datapath.
// Holds EX (and everything upstream) for multicycle ALU ops and for units
// that must signal completion, and shapes the freezes around a two-cycle flush.
//   clk, rst           : clock, synchronous active-high reset
//   ex_start           : insn enters EX this cycle
//   multicycle         : extra EX cycles for that insn (0 = single cycle)
//   wait_on            : unit the insn waits on (0 none, 1 mult/mac, 2 FPU, 3 mtspr)
//   wait_done          : done strobes [0] mult/mac, [1] FPU, [2] mtspr
//   lsu_stall, du_stall, force_dslot_fetch, flushpipe : stall/flush requests
//   *_freeze           : per-stage hold signals
//   extend_flush       : flushpipe delayed one cycle
//   wait_timeout       : one-cycle pulse when a WAIT is abandoned
//   fsm_state          : current sequencer state (debug observation)
// Handshake: ex_start is a one-cycle valid; the sequencer's "ready" is
// !id_freeze, so ex_start must never be raised while the FSM is busy.
module or1200_freeze_seq
  import or1200_freeze_pkg::*;
#(
  parameter int MC_WIDTH     = 2,
  parameter int WAIT_WIDTH   = 2,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_start,
  input  logic [MC_WIDTH-1:0]   multicycle,
  input  logic [WAIT_WIDTH-1:0] wait_on,
  input  logic [2:0]            wait_done,
  input  logic                  lsu_stall,
  input  logic                  du_stall,
  input  logic                  force_dslot_fetch,
  input  logic                  flushpipe,
  output logic                  genpc_freeze,
  output logic                  if_freeze,
  output logic                  id_freeze,
  output logic                  ex_freeze,
  output logic                  wb_freeze,
  output logic                  extend_flush,
  output logic                  wait_timeout,
  output state_t                fsm_state
);

  // A zero timeout still needs a 1-bit counter to keep widths legal.
  localparam int WC_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [WC_W-1:0] WC_LAST = (WAIT_TIMEOUT > 0) ? WC_W'(WAIT_TIMEOUT - 1) : '0;

  state_t                state;
  logic [WAIT_WIDTH-1:0] wait_on_q;
  logic [WC_W-1:0]       wait_cnt;
  logic                  extend_flush_q;
  logic [MC_WIDTH-1:0]   mc_cnt;
  logic                  mc_zero;
  logic                  mc_load;
  logic                  mc_last;
  logic                  unit_done;
  logic                  timeout_hit;
  logic                  busy;

  assign mc_load = (state == IDLE) && ex_start && !flushpipe && (multicycle != '0);

  or1200_freeze_cnt #(.W(MC_WIDTH)) u_mc_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (flushpipe),
    .load     (mc_load),
    .load_val (multicycle),
    .dec      (state == MC),
    .cnt      (mc_cnt),
    .zero     (mc_zero)
  );

  // Treat an unexpected zero count in MC as the last cycle so MC can never stick.
  assign mc_last = (mc_cnt == MC_WIDTH'(1)) || mc_zero;

  // Only the strobe of the unit latched at EX entry can release WAIT.
  always_comb begin
    unit_done = 1'b0;
    case (wait_on_q)
      WAIT_WIDTH'(WAIT_MULMAC): unit_done = wait_done[0];
      WAIT_WIDTH'(WAIT_FPU):    unit_done = wait_done[1];
      WAIT_WIDTH'(WAIT_MTSPR):  unit_done = wait_done[2];
      default:                  unit_done = 1'b0;
    endcase
  end

  assign timeout_hit = (WAIT_TIMEOUT != 0) && (wait_cnt == WC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wait_on_q      <= '0;
      wait_cnt       <= '0;
      extend_flush_q <= 1'b0;
    end else begin
      extend_flush_q <= flushpipe;
      if (flushpipe) begin
        // Flush wins over everything, including a same-cycle ex_start.
        state    <= IDLE;
        wait_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (ex_start) begin
              // wait_on is latched now so a combined MC+WAIT op remembers it.
              wait_on_q <= wait_on;
              wait_cnt  <= '0;
              if (multicycle != '0) begin
                state <= MC;
              end else if (wait_on != WAIT_WIDTH'(WAIT_NONE)) begin
                state <= WAIT;
              end
            end
          end
          MC: begin
            if (mc_last) begin
              state    <= (wait_on_q != WAIT_WIDTH'(WAIT_NONE)) ? WAIT : IDLE;
              wait_cnt <= '0;
            end
          end
          WAIT: begin
            if (unit_done || timeout_hit) begin
              state    <= IDLE;
              wait_cnt <= '0;
            end else if (wait_cnt != '1) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
      assert (!(ex_start && (state != IDLE)))
        else $error("or1200_freeze_seq: ex_start while busy is ignored");
    end
  end

  assign busy         = (state != IDLE);
  assign wb_freeze    = lsu_stall | du_stall;
  assign ex_freeze    = wb_freeze | busy;
  assign id_freeze    = ex_freeze | force_dslot_fetch;
  assign if_freeze    = id_freeze & ~extend_flush_q;
  assign genpc_freeze = (du_stall & ~flushpipe) | (id_freeze & ~flushpipe & ~extend_flush_q);
  assign extend_flush = extend_flush_q;
  assign wait_timeout = (state == WAIT) & timeout_hit & ~unit_done & ~flushpipe;
  assign fsm_state    = state;

endmodule

// File: tb/tb_or1200_freeze_seq.sv
// Directed bench for or1200_freeze_seq (WAIT_TIMEOUT = 8).
// Each step drives one cycle of inputs and queues the hand-derived expected
// output vector {state[1:0], genpc, if, id, ex, wb, extend_flush, wait_timeout},
// which is popped and compared mid-cycle on the falling edge.
module tb_or1200_freeze_seq;
  import or1200_freeze_pkg::*;

  logic       clk;
  logic       rst;
  logic       ex_start;
  logic [1:0] multicycle;
  logic [1:0] wait_on;
  logic [2:0] wait_done;
  logic       lsu_stall;
  logic       du_stall;
  logic       force_dslot_fetch;
  logic       flushpipe;
  logic       genpc_freeze;
  logic       if_freeze;
  logic       id_freeze;
  logic       ex_freeze;
  logic       wb_freeze;
  logic       extend_flush;
  logic       wait_timeout;
  state_t     fsm_state;

  logic [8:0] exp_q[$];
  string      tag_q[$];
  int         n_cmp = 0;
  int         n_mis = 0;

  // Expected vectors: {state, genpc, if, id, ex, wb, ext, to}
  localparam logic [8:0] E_IDLE = 9'b00_0000000;
  localparam logic [8:0] E_MC   = 9'b01_1111000;
  localparam logic [8:0] E_WT   = 9'b10_1111000;

  or1200_freeze_seq #(
    .MC_WIDTH     (2),
    .WAIT_WIDTH   (2),
    .WAIT_TIMEOUT (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_start          (ex_start),
    .multicycle        (multicycle),
    .wait_on           (wait_on),
    .wait_done         (wait_done),
    .lsu_stall         (lsu_stall),
    .du_stall          (du_stall),
    .force_dslot_fetch (force_dslot_fetch),
    .flushpipe         (flushpipe),
    .genpc_freeze      (genpc_freeze),
    .if_freeze         (if_freeze),
    .id_freeze         (id_freeze),
    .ex_freeze         (ex_freeze),
    .wb_freeze         (wb_freeze),
    .extend_flush      (extend_flush),
    .wait_timeout      (wait_timeout),
    .fsm_state         (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard check: pop one expectation and compare with the DUT
  task automatic check_out();
    logic [8:0] obs;
    logic [8:0] e;
    string      t;
    obs = {fsm_state, genpc_freeze, if_freeze, id_freeze, ex_freeze,
           wb_freeze, extend_flush, wait_timeout};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (obs === e)
      else begin
        n_mis++;
        $error("FAIL %s: observed %b expected %b", t, obs, e);
      end
  endtask

  // Driver: one cycle of inputs plus its expected outputs
  task automatic step(input logic r, input logic es, input logic [1:0] mc,
                      input logic [1:0] wo, input logic [2:0] dn,
                      input logic ls, input logic ds, input logic df,
                      input logic fl, input logic [8:0] ex, input string tag);
    rst               = r;
    ex_start          = es;
    multicycle        = mc;
    wait_on           = wo;
    wait_done         = dn;
    lsu_stall         = ls;
    du_stall          = ds;
    force_dslot_fetch = df;
    flushpipe         = fl;
    exp_q.push_back(ex);
    tag_q.push_back(tag);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input logic [8:0] ex, input string tag);
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, ex, tag);
  endtask

  initial begin
    rst = 1'b1; ex_start = 1'b0; multicycle = '0; wait_on = '0; wait_done = '0;
    lsu_stall = 1'b0; du_stall = 1'b0; force_dslot_fetch = 1'b0; flushpipe = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step(1'b1, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "reset");
    quiet(E_IDLE, "post_reset");

    // multicycle=2: freeze exactly T+1..T+2
    step(1'b0, 1'b1, 2'd2, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "mc2_T");
    quiet(E_MC, "mc2_T1");
    quiet(E_MC, "mc2_T2");
    quiet(E_IDLE, "mc2_T3");

    // multicycle=3: freeze exactly T+1..T+3
    step(1'b0, 1'b1, 2'd3, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "mc3_T");
    for (int i = 1; i <= 3; i++) quiet(E_MC, $sformatf("mc3_T%0d", i));
    quiet(E_IDLE, "mc3_T4");

    // WAIT on FPU, mult/mac strobe ignored, FPU done at T+5
    step(1'b0, 1'b1, 2'd0, 2'd2, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "fpu_T");
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, E_WT, "fpu_T1");
    quiet(E_WT, "fpu_T2");
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, E_WT, "fpu_T3");
    quiet(E_WT, "fpu_T4");
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, E_WT, "fpu_T5");
    quiet(E_IDLE, "fpu_T6");

    // WAIT on mult/mac never done: timeout pulse at T+8
    step(1'b0, 1'b1, 2'd0, 2'd1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "to_T");
    quiet(E_WT, "to_T1");
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, E_WT, "to_T2");
    for (int i = 3; i <= 7; i++) quiet(E_WT, $sformatf("to_T%0d", i));
    quiet(9'b10_1111001, "to_T8");
    quiet(E_IDLE, "to_T9");

    // multicycle=3 then flush at T+1
    step(1'b0, 1'b1, 2'd3, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "mcfl_T");
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 9'b01_0111000, "mcfl_T1");
    quiet(9'b00_0000010, "mcfl_T2");
    quiet(E_IDLE, "mcfl_T3");

    // ex_start and flush together: no MC entry; if_freeze low during extend_flush
    step(1'b0, 1'b1, 2'd2, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, E_IDLE, "esfl_T");
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 9'b00_0010010, "esfl_T1");
    quiet(E_IDLE, "esfl_T2");

    // lsu_stall for 4 cycles around a multicycle=1 op
    step(1'b0, 1'b1, 2'd1, 2'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 9'b00_1111100, "lsu_T");
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 9'b01_1111100, "lsu_T1");
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 9'b00_1111100, "lsu_T2");
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 9'b00_1111100, "lsu_T3");
    quiet(E_IDLE, "lsu_T4");

    // multicycle=1 plus mtspr wait: MC then WAIT; done ignored while in MC
    step(1'b0, 1'b1, 2'd1, 2'd3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "mcw_T");
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, E_MC, "mcw_T1");
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, E_WT, "mcw_T2");
    quiet(E_IDLE, "mcw_T3");

    // Debug stall and flush interaction; flush during lsu_stall keeps wb_freeze
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 9'b00_1111100, "du");
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 9'b00_0111100, "du_fl");
    quiet(9'b00_0000010, "du_fl_ext");
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 9'b00_0111100, "lsu_fl");
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 9'b00_0011110, "lsu_fl_ext");
    quiet(E_IDLE, "lsu_fl_done");

    // Reset in the middle of WAIT
    step(1'b0, 1'b1, 2'd0, 2'd2, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "rstw_T");
    quiet(E_WT, "rstw_T1");
    step(1'b1, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, E_WT, "rstw_T2");
    step(1'b0, 1'b0, 2'd0, 2'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "rstw_T3");

    // After reset, a fresh WAIT must run the full timeout again
    step(1'b0, 1'b1, 2'd0, 2'd1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "to2_T");
    for (int i = 1; i <= 7; i++) quiet(E_WT, $sformatf("to2_T%0d", i));
    quiet(9'b10_1111001, "to2_T8");
    quiet(E_IDLE, "to2_T9");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
